id_hazard_ctrl: RTL

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl_if.sv | 45 ++++
 rtl/id_hazard_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl_if.sv
// Bundle of the ID-stage hazard signals: instruction path, operand
// addresses, load issue info, forwarding sources, register-file data,
// and the forwarded/stall results going back to the pipeline.
interface id_hazard_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3
);
    logic                      stall_in;
    logic                      flush;
    logic [31:0]               inst_in;
    logic [4:0]                rs_addr;
    logic [4:0]                rt_addr;
    logic                      rs_used;
    logic                      rt_used;
    logic                      issue;
    logic                      issue_load;
    logic [4:0]                issue_waddr;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [5*NUM_FWD-1:0]      fwd_waddr;
    logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;

    logic [31:0]               inst_out;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic                      stallreq;
    logic [31:0]               stall_cnt;

    // Pipeline side: drives the ID-stage inputs, observes the results.
    modport master (
        output stall_in, flush, inst_in, rs_addr, rt_addr, rs_used, rt_used,
               issue, issue_load, issue_waddr, fwd_we, fwd_waddr, fwd_wdata,
               rf_rdata1, rf_rdata2,
        input  inst_out, rs_data, rt_data, stallreq, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  stall_in, flush, inst_in, rs_addr, rt_addr, rs_used, rt_used,
               issue, issue_load, issue_waddr, fwd_we, fwd_waddr, fwd_wdata,
               rf_rdata1, rf_rdata2,
        output inst_out, rs_data, rt_data, stallreq, stall_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard control: operand forwarding with EX > MEM > WB priority,
// instruction hold across downstream stalls, load-use stall detection via a
// pending-load shift register, and a saturating stall-cycle counter.
module id_hazard_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_FWD  = 3,
    parameter int LOAD_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    id_hazard_ctrl_if.slave bus
);

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              hold_v;
    logic [31:0]       held_word;
    logic [LOAD_LAT-1:0] pend_v;
    logic [4:0]        pend_a [LOAD_LAT];
    logic              load_hit;
    logic              stallreq_int;
    logic              fire;
    logic [31:0]       stall_cnt_q;

    // Forwarding mux: walk sources from lowest priority to highest so the
    // lowest-index match is the one that sticks; r0 is never forwarded.
    always_comb begin
        rs_fwd = bus.rf_rdata1;
        rt_fwd = bus.rf_rdata2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == bus.rs_addr) && (bus.rs_addr != 5'd0))
                rs_fwd = bus.fwd_wdata[DATA_W*i +: DATA_W];
            if (bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == bus.rt_addr) && (bus.rt_addr != 5'd0))
                rt_fwd = bus.fwd_wdata[DATA_W*i +: DATA_W];
        end
    end

    // Load-use detection against every in-flight load still short of data.
    always_comb begin
        load_hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (pend_v[k] && ((bus.rs_used && (bus.rs_addr == pend_a[k])) ||
                              (bus.rt_used && (bus.rt_addr == pend_a[k]))))
                load_hit = 1'b1;
        end
        stallreq_int = bus.issue & ~bus.flush & load_hit;
        fire = bus.issue & bus.issue_load & ~stallreq_int & ~bus.stall_in &
               ~bus.flush & (bus.issue_waddr != 5'd0);
    end

    // Pending-load pipe: advances only when the pipeline moves; a stall
    // request cycle lets an empty slot (bubble) in behind the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                pend_v[k] <= 1'b0;
                pend_a[k] <= 5'd0;
            end
        end else if (!bus.stall_in) begin
            pend_v[0] <= fire;
            pend_a[0] <= fire ? bus.issue_waddr : 5'd0;
            for (int k = 1; k < LOAD_LAT; k++) begin
                pend_v[k] <= pend_v[k-1];
                pend_a[k] <= pend_a[k-1];
            end
        end
    end

    // Hold register: capture the word on the first stalled cycle; flush
    // wins over capture and drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            held_word <= 32'd0;
        end else if (bus.flush) begin
            hold_v <= 1'b0;
        end else if (bus.stall_in && !hold_v) begin
            hold_v    <= 1'b1;
            held_word <= bus.inst_in;
        end else if (!bus.stall_in) begin
            hold_v <= 1'b0;
        end
    end

    // Saturating count of stall-request cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 32'd0;
        else if (stallreq_int && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    // Output drive; the held word is only shown while the stall persists so
    // release returns to the live fetch word in the same cycle.
    always_comb begin
        if (bus.flush)
            bus.inst_out = 32'd0;
        else if (hold_v && bus.stall_in)
            bus.inst_out = held_word;
        else
            bus.inst_out = bus.inst_in;
        bus.rs_data   = rs_fwd;
        bus.rt_data   = rt_fwd;
        bus.stallreq  = stallreq_int;
        bus.stall_cnt = stall_cnt_q;
    end

endmodule
